// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: single-outstanding req/ack bus handshake,
// byte-enable/store-data generation, alignment exceptions and bus timeout.
//
// state | meaning
// IDLE  | ready for a new access from the MEM stage
// BUS   | bus_req asserted, waiting for bus_ack or timeout
// RESP  | one-cycle response strobe, then back to IDLE
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  ext_a,
  output logic [2:0]  ext_op,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        rsp_err,
  output logic        stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  logic [1:0]      state;
  logic [2:0]      op_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cnt_inc;
  logic            to_hit;
  logic            st_in;
  logic            st_q;
  logic            mis_in;
  logic [3:0]      be_c;
  logic [31:0]     wd_c;

  assign st_in   = (req_op >= 3'd5);
  assign st_q    = (op_q >= 3'd5);
  assign cnt_inc = cnt + 1'b1;
  assign to_hit  = (TIMEOUT != 0) && (cnt_inc == TO_LIM);

  always_comb begin
    mis_in = 1'b0;
    case (req_op)
      3'd0, 3'd5:       mis_in = (req_addr[1:0] != 2'b00);
      3'd3, 3'd4, 3'd6: mis_in = req_addr[0];
      default:          mis_in = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
      ext_a     <= '0;
      ext_op    <= '0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            ext_a     <= req_addr[1:0];
            ext_op    <= st_in ? 3'b000 : req_op;
            rsp_rdata <= '0;
            cnt       <= '0;
            if (mis_in) begin
              exc_adel <= ~st_in;
              exc_ades <= st_in;
              state    <= RESP;
            end else begin
              state <= BUS;
            end
          end
        end
        BUS: begin
          // ack takes priority over a timeout expiring in the same cycle
          if (bus_ack) begin
            if (!st_q) rsp_rdata <= bus_rdata;
            cnt   <= '0;
            state <= RESP;
          end else if (to_hit) begin
            cnt     <= '0;
            rsp_err <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RESP: begin
          exc_adel <= 1'b0;
          exc_ades <= 1'b0;
          rsp_err  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    be_c = 4'b1111;
    wd_c = wdata_q;
    case (op_q)
      3'd6: begin
        be_c = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{wdata_q[15:0]}};
      end
      3'd7: begin
        be_c = 4'b0001 << addr_q[1:0];
        wd_c = {4{wdata_q[7:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = wdata_q;
      end
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign bus_req   = (state == BUS);
  assign bus_we    = bus_req & st_q;
  assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_be    = bus_req ? be_c : 4'b0000;
  assign bus_wdata = (bus_req && st_q) ? wd_c : 32'h0;
  assign stall     = ((state == IDLE) && req_valid) || (state == BUS);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed plan steps plus random
// accesses checked against a size/offset based reference model.
module tb_mem_access_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  ext_a;
  logic [2:0]  ext_op;
  logic        exc_adel, exc_ades, rsp_err, stall;

  int checks = 0;
  int failures = 0;

  mem_access_ctrl #(.TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ext_a(ext_a), .ext_op(ext_op),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .rsp_err(rsp_err), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd5) return 4;
    if (op == 3'd3 || op == 3'd4 || op == 3'd6) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] addr);
    int sz;
    sz = m_size(op);
    if (op < 3'd5) return 4'hF;
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = m_size(op);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  // d = idle bus cycles before ack (ack lands on bus cycle d+1)
  task automatic access(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int d, input logic [31:0] rd);
    bit mis, st, err;
    int nbus;
    logic [31:0] exp_rd;
    mis  = (addr % m_size(op)) != 0;
    st   = (op >= 3'd5);
    err  = (d + 1 > TMO);
    nbus = err ? TMO : d + 1;
    exp_rd = (!st && !mis && !err) ? rd : 32'h0;

    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    #1 chk("accept_stall", 32'(stall), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    if (!mis) begin
      for (int i = 1; i <= nbus; i++) begin
        chk("bus_req", 32'(bus_req), 32'd1);
        chk("bus_we", 32'(bus_we), 32'(st));
        chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
        chk("bus_be", 32'(bus_be), 32'(m_be(op, addr)));
        if (st) chk("bus_wdata", bus_wdata, m_wdata(op, wd));
        chk("bus_stall", 32'(stall), 32'd1);
        chk("bus_no_rsp", 32'(rsp_valid), 32'd0);
        bus_ack   = (i == d + 1);
        bus_rdata = (i == d + 1) ? rd : $urandom;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = $urandom;
      end
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_bus_req", 32'(bus_req), 32'd0);
    chk("rsp_stall", 32'(stall), 32'd0);
    chk("rsp_ready", 32'(req_ready), 32'd0);
    chk("exc_adel", 32'(exc_adel), 32'(mis && !st));
    chk("exc_ades", 32'(exc_ades), 32'(mis && st));
    chk("rsp_err", 32'(rsp_err), 32'(err && !mis));
    chk("ext_a", 32'(ext_a), addr % 4);
    chk("ext_op", 32'(ext_op), st ? 32'd0 : 32'(op));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_flags", {29'd0, exc_adel, exc_ades, rsp_err}, 32'd0);
    chk("hold_ext_a", 32'(ext_a), addr % 4);
    chk("hold_ext_op", 32'(ext_op), st ? 32'd0 : 32'(op));
    chk("hold_rdata", rsp_rdata, exp_rd);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ext", {27'd0, ext_a, ext_op}, 32'd0);
    chk("rst_flags", {29'd0, exc_adel, exc_ades, rsp_err}, 32'd0);
    reset = 1'b1;

    access(3'd2, 32'h0000_1003, 32'h0, 0, 32'h80FF_00FF);
    access(3'd6, 32'h0000_2002, 32'h1234_ABCD, 1, 32'hDEAD_BEEF);
    access(3'd7, 32'h0000_2001, 32'h0000_00EE, 0, 32'hDEAD_BEEF);
    access(3'd0, 32'h0000_3001, 32'h0, 0, 32'h1111_2222);
    access(3'd6, 32'h0000_3003, 32'h5555_6666, 0, 32'h0);
    access(3'd3, 32'h0000_4002, 32'h0, 3, 32'hCAFE_F00D);
    access(3'd0, 32'h0000_6000, 32'h0, 20, 32'h0);
    access(3'd0, 32'h0000_6004, 32'h0, TMO - 1, 32'h7777_8888);

    // reset mid-access: bus_req must drop at once and no response follows
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h0000_7000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_rst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("after_rst_ready", 32'(req_ready), 32'd1);
    end
    access(3'd5, 32'h0000_5000, 32'hA5A5_5A5A, 1, 32'h0);

    for (int n = 0; n < 40; n++) begin
      access(3'($urandom_range(0, 7)), $urandom, $urandom,
             int'($urandom_range(0, 5)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
